// File: rtl/cordic_arbiter_if.sv
// -----------------------------------------------------------------------------
// cordic_arbiter_if
//   Bundles the requester-side and core-side signals of cordic_arbiter.
//
//   Requester side:
//     req_valid  [NUM_REQ]     per-requester request valid
//     req_rad    [NUM_REQ*32]  per-requester angle, slice i = [32*i +: 32]
//     req_ready  [NUM_REQ]     one-hot grant
//     rsp_valid  [NUM_REQ]     one-hot response strobe
//     rsp_sin    [16]          shared result sine
//     rsp_cos    [16]          shared result cosine
//   Core side:
//     cordic_rad [32]          angle to the core
//     cordic_vin               valid_in to the core
//     cordic_vout              valid_out from the core
//     cordic_s   [16]          sine from the core
//     cordic_c   [16]          cosine from the core
//
//   Modports:
//     slave  - the arbiter's view
//     master - the surrounding voices and core
// -----------------------------------------------------------------------------
interface cordic_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_rad;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [15:0]           rsp_sin;
  logic [15:0]           rsp_cos;
  logic [31:0]           cordic_rad;
  logic                  cordic_vin;
  logic                  cordic_vout;
  logic [15:0]           cordic_s;
  logic [15:0]           cordic_c;

  modport slave (
    input  req_valid, req_rad, cordic_vout, cordic_s, cordic_c,
    output req_ready, rsp_valid, rsp_sin, rsp_cos, cordic_rad, cordic_vin
  );

  modport master (
    output req_valid, req_rad, cordic_vout, cordic_s, cordic_c,
    input  req_ready, rsp_valid, rsp_sin, rsp_cos, cordic_rad, cordic_vin
  );
endinterface

// File: rtl/cordic_arbiter.sv
// -----------------------------------------------------------------------------
// cordic_arbiter
//   Shares one pipelined CORDIC sin/cos core between NUM_REQ phase requesters.
//   Round-robin grant, at most one issue per clock. The requester index rides
//   in a tag pipeline alongside the core so each result is steered back to the
//   requester that issued it.
//
//   Parameters:
//     NUM_REQ  number of requesters (2..16)
//     LATENCY  core latency, cordic_vin to cordic_vout, in clocks
//
//   Ports:
//     clock     system clock, rising edge
//     reset     asynchronous, active-low reset
//     bus       cordic_arbiter_if.slave (request, response and core signals)
//     busy      high while an issue or any tag stage is in flight
//     err_sync  sticky: core valid_out disagreed with the tag pipeline
//
//   Build option:
//     CORDIC_ARB_PRIO_EN  when defined, requester 0 has fixed highest priority
//                         and does not move the round-robin pointer; the
//                         others rotate among themselves.
// -----------------------------------------------------------------------------
module cordic_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 16
) (
  input  logic            clock,
  input  logic            reset,
  cordic_arbiter_if.slave bus,
  output logic            busy,
  output logic            err_sync
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int SUM_W = IDX_W + 1;

`ifdef CORDIC_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   ptr_next;
  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_vec;
  logic [SUM_W-1:0]   scan_sum;
  logic [IDX_W-1:0]   scan_idx;

  logic [IDX_W-1:0]   issue_idx;
  logic [LATENCY-1:0] tag_v;
  logic [IDX_W-1:0]   tag_idx [LATENCY];
  logic [NUM_REQ-1:0] rsp_onehot;

  // Grant scan: walk ptr, ptr+1, ... modulo NUM_REQ and take the first pending
  // requester. With priority enabled, requester 0 wins outright and is
  // skipped by the rotating scan.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    if (PRIO_EN && bus.req_valid[0]) begin
      grant_found = 1'b1;
      grant_idx   = '0;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, ptr} + SUM_W'(k);
      if (scan_sum >= SUM_W'(NUM_REQ)) begin
        scan_sum = scan_sum - SUM_W'(NUM_REQ);
      end
      scan_idx = scan_sum[IDX_W-1:0];
      if (!grant_found && bus.req_valid[scan_idx] && !(PRIO_EN && scan_idx == '0)) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    if (grant_found) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  // Grant is forced low while reset is held so no requester sees a phantom
  // handshake during reset.
  assign bus.req_ready = reset ? grant_vec : '0;

  // A priority grant to requester 0 leaves the rotation where it was.
  always_comb begin
    ptr_next = ptr;
    if (grant_found && !(PRIO_EN && grant_idx == '0)) begin
      ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Issue register: angle and valid to the core, plus the index that starts
  // its journey down the tag pipeline.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr            <= '0;
      bus.cordic_rad <= '0;
      bus.cordic_vin <= 1'b0;
      issue_idx      <= '0;
    end else begin
      ptr            <= ptr_next;
      bus.cordic_vin <= grant_found;
      issue_idx      <= grant_idx;
      if (grant_found) begin
        bus.cordic_rad <= bus.req_rad[{grant_idx, 5'b00000} +: 32];
      end
    end
  end

  // The core sees valid_in the cycle after the handshake and answers LATENCY
  // cycles later, so the tags are fed from the issue register rather than the
  // raw grant; that lines the last stage up with cordic_vout. Never stalls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_v <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_idx[i] <= '0;
      end
    end else begin
      tag_v[0]   <= bus.cordic_vin;
      tag_idx[0] <= issue_idx;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  always_comb begin
    rsp_onehot = '0;
    rsp_onehot[tag_idx[LATENCY-1]] = 1'b1;
  end

  // Response steering and sync check. A result with no matching tag, or a tag
  // with no result, latches err_sync; a tag without a result is dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.rsp_valid <= '0;
      bus.rsp_sin   <= '0;
      bus.rsp_cos   <= '0;
      err_sync      <= 1'b0;
    end else begin
      if (tag_v[LATENCY-1] && bus.cordic_vout) begin
        bus.rsp_valid <= rsp_onehot;
        bus.rsp_sin   <= bus.cordic_s;
        bus.rsp_cos   <= bus.cordic_c;
      end else begin
        bus.rsp_valid <= '0;
      end
      if (tag_v[LATENCY-1] != bus.cordic_vout) begin
        err_sync <= 1'b1;
      end
    end
  end

  assign busy = (|tag_v) | bus.cordic_vin;

endmodule

// File: tb/tb_cordic_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cordic_arbiter
//   Self-checking bench for cordic_arbiter. A behavioural core model answers
//   LATENCY cycles after valid_in. A reference arbiter (distance-from-pointer
//   rule) predicts each grant; every handshake pushes the expected response
//   and its due cycle into a scoreboard that a separate monitor drains.
// -----------------------------------------------------------------------------
module tb_cordic_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LAT     = 16;

  typedef struct {
    int          g;
    logic [15:0] s;
    logic [15:0] c;
    int          due;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic busy;
  logic err_sync;
  logic force_vout = 1'b0;

  cordic_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  cordic_arbiter #(.NUM_REQ(NUM_REQ), .LATENCY(LAT)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .err_sync (err_sync)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t sb[$];
  int   model_ptr = 0;
  bit   model_err = 1'b0;
  bit   have_hs   = 1'b0;
  int   last_hs   = 0;
  logic [NUM_REQ-1:0] last_ready;

  // Arbitrary but distinct functions standing in for the core's sin/cos.
  function automatic logic [15:0] core_sin(input logic [31:0] rad);
    return rad[31:16] ^ rad[15:0];
  endfunction

  function automatic logic [15:0] core_cos(input logic [31:0] rad);
    return rad[15:0] + 16'h1234;
  endfunction

  // Behavioural core: LAT-deep delay line, shares the arbiter's reset.
  logic        core_v   [LAT];
  logic [31:0] core_rad [LAT];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) begin
        core_v[i]   <= 1'b0;
        core_rad[i] <= '0;
      end
    end else begin
      core_v[0]   <= bus.cordic_vin;
      core_rad[0] <= bus.cordic_rad;
      for (int i = 1; i < LAT; i++) begin
        core_v[i]   <= core_v[i-1];
        core_rad[i] <= core_rad[i-1];
      end
    end
  end

  assign bus.cordic_vout = core_v[LAT-1] | force_vout;
  assign bus.cordic_s    = core_sin(core_rad[LAT-1]);
  assign bus.cordic_c    = core_cos(core_rad[LAT-1]);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference grant: the pending requester closest to the pointer going
  // upward modulo NUM_REQ; -1 if nothing is pending.
  function automatic int model_pick(input logic [NUM_REQ-1:0] v);
    int best   = -1;
    int best_d = NUM_REQ;
    int d;
`ifdef CORDIC_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef CORDIC_ARB_PRIO_EN
      if (i == 0) continue;
`endif
      if (v[i]) begin
        d = (i - model_ptr + NUM_REQ) % NUM_REQ;
        if (d < best_d) begin
          best_d = d;
          best   = i;
        end
      end
    end
    return best;
  endfunction

  function automatic bit model_busy();
    return have_hs && ((cyc - last_hs) <= LAT + 1);
  endfunction

  // One clock of stimulus: check status, drive inputs, check the grant and
  // record the expected response for any handshake.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*32-1:0] rads);
    int          g;
    logic [31:0] r;
    exp_t        e;
    @(negedge clock);
    checkOutput("busy", 64'(busy), 64'(model_busy()));
    checkOutput("err_sync", 64'(err_sync), 64'(model_err));
    bus.req_valid = v;
    bus.req_rad   = rads;
    #1;
    g = model_pick(v);
    checkOutput("req_ready", 64'(bus.req_ready), (g >= 0) ? (64'(1) << g) : 64'(0));
    last_ready = bus.req_ready;
    if (g >= 0) begin
      r     = 32'(rads >> (32 * g));
      e.g   = g;
      e.s   = core_sin(r);
      e.c   = core_cos(r);
      e.due = cyc + LAT + 2;
      sb.push_back(e);
`ifdef CORDIC_ARB_PRIO_EN
      if (g != 0) model_ptr = (g + 1) % NUM_REQ;
`else
      model_ptr = (g + 1) % NUM_REQ;
`endif
      have_hs = 1'b1;
      last_hs = cyc;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < LAT + 10 && sb.size() != 0; i++) begin
      applyStimulus('0, '0);
    end
    checkOutput("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  function automatic logic [NUM_REQ*32-1:0] rand_rads();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: compares every response strobe against the scoreboard.
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (!reset) continue;
      while (sb.size() > 0 && sb[0].due < cyc) begin
        checkOutput("rsp_late", 64'(cyc), 64'(sb[0].due));
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(1) << mon_e.g);
        checkOutput("rsp_sin", 64'(bus.rsp_sin), 64'(mon_e.s));
        checkOutput("rsp_cos", 64'(bus.rsp_cos), 64'(mon_e.c));
      end else begin
        checkOutput("rsp_idle", 64'(bus.rsp_valid), 64'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req_valid = '1;
    bus.req_rad   = rand_rads();
    repeat (3) @(negedge clock);
    checkOutput("rst_req_ready", 64'(bus.req_ready), 64'(0));
    checkOutput("rst_cordic_vin", 64'(bus.cordic_vin), 64'(0));
    checkOutput("rst_cordic_rad", 64'(bus.cordic_rad), 64'(0));
    checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    checkOutput("rst_rsp_sin", 64'(bus.rsp_sin), 64'(0));
    checkOutput("rst_rsp_cos", 64'(bus.rsp_cos), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_err_sync", 64'(err_sync), 64'(0));
    bus.req_valid = '0;
    reset = 1'b1;

`ifndef CORDIC_ARB_PRIO_EN
    $display("[TB] all four requesters from ptr=0");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'hF, rand_rads());
      checkOutput("rr_all_grant", 64'(last_ready), 64'(1) << (i % 4));
    end
    $display("[TB] requesters 0 and 2 alternate");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0101, rand_rads());
      checkOutput("rr_0101_grant", 64'(last_ready), (i % 2 == 0) ? 64'h1 : 64'h4);
    end
`else
    $display("[TB] requester 0 priority");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'hF, rand_rads());
      checkOutput("prio_grant0", 64'(last_ready), 64'h1);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'hE, rand_rads());
      checkOutput("prio_rr_grant", 64'(last_ready), 64'(1) << ((i % 3) + 1));
    end
`endif
    drain();

    $display("[TB] single request");
    applyStimulus(4'b0001, '0);
    applyStimulus('0, '0);
    checkOutput("single_vin_high", 64'(bus.cordic_vin), 64'(1));
    checkOutput("single_rad", 64'(bus.cordic_rad), 64'(0));
    applyStimulus('0, '0);
    checkOutput("single_vin_low", 64'(bus.cordic_vin), 64'(0));
    drain();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      logic [NUM_REQ-1:0] v;
      v = NUM_REQ'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) v = '1;
      applyStimulus(v, rand_rads());
    end
    drain();
    repeat (2) applyStimulus('0, '0);

    $display("[TB] spurious core valid_out");
    @(negedge clock);
    force_vout = 1'b1;
    @(negedge clock);
    force_vout = 1'b0;
    checkOutput("err_set", 64'(err_sync), 64'(1));
    model_err = 1'b1;
    repeat (4) applyStimulus('0, '0);

    $display("[TB] reset mid-flight");
    for (int i = 0; i < 5; i++) applyStimulus(4'hF, rand_rads());
    @(negedge clock);
    reset         = 1'b0;
    bus.req_valid = '1;
    sb.delete();
    have_hs   = 1'b0;
    model_ptr = 0;
    model_err = 1'b0;
    #1;
    checkOutput("midrst_req_ready", 64'(bus.req_ready), 64'(0));
    checkOutput("midrst_busy", 64'(busy), 64'(0));
    checkOutput("midrst_err_sync", 64'(err_sync), 64'(0));
    @(negedge clock);
    reset         = 1'b1;
    bus.req_valid = '0;
    repeat (LAT + 5) applyStimulus('0, '0);
    applyStimulus(4'b0100, rand_rads());
    drain();
    repeat (2) applyStimulus('0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
